regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the shrv32 core. Single clock replaces the separate decode and writeback strobes.
- NR registered read ports with write-to-read forwarding, one write port, and hardwired zero register.
- Pending-write scoreboard: decode marks a destination busy at issue, writeback clears it. Decode uses BUSY to stall.
- Keeps the LED tap and the top-register debug tap (TAP) used by board I/O.

Parameters:
- XLEN, 32, register width in bits
- NREG, 32, number of registers (power of 2, ≥ 4); AW = $clog2(NREG) derived internally
- NR, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/issues; 0 = ordinary register
- LED_REG, NREG-1, register index driven onto LED
- LED_W, 8, LED width (≤ XLEN)
- TAP_N, 8, number of top registers exported on TAP (≤ NREG)

Ports:
- CLK  in  1  core clock, rising edge
- RST  in  1  asynchronous reset, active-low
- RE  in  1  read enable; capture all read ports this edge
- RA  in  NR*AW  read addresses; port i = RA[i*AW +: AW]
- RD  out  NR*XLEN  registered read data; port i = RD[i*XLEN +: XLEN]
- BUSY  out  NR  combinational; port i source has a pending write
- WE  in  1  write enable
- WA  in  AW  write address
- WD  in  XLEN  write data
- ISSUE  in  1  mark IA pending
- IA  in  AW  issue destination address
- LED  out  LED_W  reg[LED_REG][LED_W-1:0], combinational from the array
- TAP  out  TAP_N*XLEN  {reg[NREG-TAP_N], ..., reg[NREG-1]}; reg[NREG-1] in the LSBs

Behaviour:
- Reset (RST=0, async): all registers 0, all pending bits 0, RD=0. Hence LED=0, TAP=0, BUSY=0. Deassertion is synchronised externally.
- Write: at posedge with WE=1, reg[WA] <= WD. If ZERO_REG=1 and WA=0, the write is dropped.
- Read latency is 1 cycle. At posedge with RE=1, each port i loads RD_i:
  - if WE=1, WA=RA_i and the write is not dropped: WD (same-edge forwarding);
  - else if ZERO_REG=1 and RA_i=0: 0;
  - else: reg[RA_i].
- RE=0: RD holds its value regardless of writes.
- Multiple ports may read the same address; each receives identical data.
- Scoreboard, one bit per register:
  - ISSUE=1 sets pend[IA].
  - WE=1 clears pend[WA].
  - ISSUE and WE to the same address on the same edge: set wins. The new producer supersedes the old one.
  - ISSUE to IA=0 with ZERO_REG=1 is ignored.
  - Re-issuing an already-pending register is legal; the bit stays 1. No count is kept.
- BUSY_i = pend[RA_i] AND NOT (WE=1 AND WA=RA_i). Forwarding resolves a same-cycle writeback.
  - ISSUE in the current cycle does not affect BUSY until the next edge.
  - BUSY_i is always 0 for RA_i=0 when ZERO_REG=1.
- LED and TAP reflect array contents after the write edge. There is no forwarding on these outputs.
- Reset asserted mid-operation clears everything immediately. Any write or issue on that edge is lost.
- Out-of-range addresses cannot occur (NREG is a power of 2).

Test Plan:
- Reset: write reg5=0xDEADBEEF, issue 7, assert RST=0 asynchronously mid-cycle → RD=0, BUSY=0, LED=0, TAP=0 immediately. Read 5 after release → 0.
- Write/read: WE, WA=3, WD=0x12345678. Next cycle RE, RA0=3, RA1=3 → both ports 0x12345678 one edge later. RE=0 with a new write to 3 → RD unchanged.
- Forwarding: same edge WE, WA=10, WD=0xA5A5A5A5 and RE, RA0=10 → RD0=0xA5A5A5A5. RA1=0 with WA=0 write of 0xFFFFFFFF → RD1=0.
- Scoreboard: ISSUE IA=4 → next cycle RA0=4 gives BUSY0=1. WE WA=4 drives BUSY0=0 combinationally that cycle. After the edge pend[4]=0. ISSUE IA=4 and WE WA=4 on the same edge → BUSY0=1 afterwards.
- Taps: write reg31=0x000000C3 and reg24=0x11111111 → LED=0xC3, TAP[31:0]=0x000000C3, TAP[255:224]=0x11111111.
- Parameter sweep: NR=3, NREG=16, ZERO_REG=0 → writes to reg0 stick (0x55 read back). Three ports read distinct addresses 1/2/15 correctly. TAP_N=8 covers regs 8..15.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file for the shrv32 core: registered read ports with write forwarding,
// one write port, a pending-write scoreboard for decode stalls, and LED/TAP board taps.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1,
  parameter int LED_REG  = NREG - 1,
  parameter int LED_W    = 8,
  parameter int TAP_N    = 8,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RE,
  input  logic [NR*AW-1:0]      RA,
  output logic [NR*XLEN-1:0]    RD,
  output logic [NR-1:0]         BUSY,
  input  logic                  WE,
  input  logic [AW-1:0]         WA,
  input  logic [XLEN-1:0]       WD,
  input  logic                  ISSUE,
  input  logic [AW-1:0]         IA,
  output logic [LED_W-1:0]      LED,
  output logic [TAP_N*XLEN-1:0] TAP
);

  localparam bit            ZR      = (ZERO_REG != 0);
  localparam logic [AW-1:0] LED_IDX = AW'(LED_REG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic            wr_ok;
  logic            iss_ok;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign wr_ok  = WE && !(ZR && (WA == '0));
  assign iss_ok = ISSUE && !(ZR && (IA == '0));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else if (wr_ok) begin
      regs[WA] <= WD;
    end
  end

  // Clear first, then set: a new issue to the address being written back wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend <= '0;
    end else begin
      if (WE)     pend[WA] <= 1'b0;
      if (iss_ok) pend[IA] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NR; g++) begin : g_port
    logic [AW-1:0]   ra;
    logic            fwd;
    logic [XLEN-1:0] rd_next;
    logic [XLEN-1:0] rd_q;

    assign ra      = RA[g*AW +: AW];
    assign fwd     = wr_ok && (WA == ra);
    assign rd_next = fwd ? WD : ((ZR && (ra == '0)) ? '0 : regs[ra]);
    assign BUSY[g] = pend[ra] && !(WE && (WA == ra)) && !(ZR && (ra == '0));

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        rd_q <= '0;
      end else if (RE) begin
        rd_q <= rd_next;
      end
    end

    assign RD[g*XLEN +: XLEN] = rd_q;
  end

  assign LED = regs[LED_IDX][LED_W-1:0];

  // Topmost register lands in the least significant slot of TAP.
  for (genvar t = 0; t < TAP_N; t++) begin : g_tap
    assign TAP[t*XLEN +: XLEN] = regs[NREG-1-t];
  end

endmodule
